// File: rtl/display_pkg.sv
// Shared constants and types for the stopwatch 4-digit 7-segment scan controller.
package display_pkg;

  localparam int unsigned VAL_W  = 6;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned SLOT_W = 2;

  localparam logic [SLOT_W-1:0] SLOT_SEC_ONES = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_SEC_TENS = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_MIN_ONES = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_MIN_TENS = 2'd3;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  localparam logic [AN_W-1:0] AN_OFF = 4'b1111;
  localparam logic [AN_W-1:0] AN_SLOT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam logic [VAL_W-1:0] MAX_VAL = 6'd59;

  typedef struct packed {
    logic [VAL_W-1:0] min;
    logic [VAL_W-1:0] sec;
  } snap_t;

  function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// 4-bit BCD to active-low 7-segment pattern; non-decimal codes blank the digit.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/digits.sv
// Binary (0-59) to two BCD digits; shared by the minutes and seconds fields.
module digits
  import display_pkg::*;
(
  input  logic [VAL_W-1:0] bin,
  output logic [BCD_W-1:0] tens_c,
  output logic [BCD_W-1:0] ones_c
);

  logic [VAL_W-1:0] rem;

  // Range compare is cheaper than a general divider for a 6-bit input capped at 59
  always_comb begin
    tens_c = '0;
    rem    = bin;
    if (bin >= VAL_W'(50)) begin
      tens_c = BCD_W'(5);
      rem    = bin - VAL_W'(50);
    end else if (bin >= VAL_W'(40)) begin
      tens_c = BCD_W'(4);
      rem    = bin - VAL_W'(40);
    end else if (bin >= VAL_W'(30)) begin
      tens_c = BCD_W'(3);
      rem    = bin - VAL_W'(30);
    end else if (bin >= VAL_W'(20)) begin
      tens_c = BCD_W'(2);
      rem    = bin - VAL_W'(20);
    end else if (bin >= VAL_W'(10)) begin
      tens_c = BCD_W'(1);
      rem    = bin - VAL_W'(10);
    end
    ones_c = BCD_W'(rem);
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Stopwatch MM:SS display scanner with per-slot blanking gap.
// Optional field blink in adjust mode is enabled by defining ADJ_BLINK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] min_val,
  input  logic [VAL_W-1:0] sec_val,
  input  logic             load,
  input  logic             adj_en,
  input  logic             adj_sel,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             dp
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  snap_t             snap_q;
  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [VAL_W-1:0]  conv_q, conv_n;
  logic [SEG_W-1:0]  seg_q, seg_n;
  logic [AN_W-1:0]   an_q, an_n;
  logic              dp_q, dp_n;
  logic              hide_q, hide_n;

  logic [BCD_W-1:0]  tens_c, ones_c, bcd_sel_c;
  logic [SEG_W-1:0]  seg_dec_c;
  logic              field_hide_c;

  // Snapshot with clamp to 59
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (load) begin
      snap_q <= '{min: clamp_val(min_val), sec: clamp_val(sec_val)};
    end
  end

  digits u_digits (
    .bin    (conv_q),
    .tens_c (tens_c),
    .ones_c (ones_c)
  );

  assign bcd_sel_c = slot_q[0] ? tens_c : ones_c;

  bcd_to_seg u_bcd_to_seg (
    .bcd   (bcd_sel_c),
    .seg_c (seg_dec_c)
  );

`ifdef ADJ_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_on_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
    end
  end

  // Seconds field lives in slots 0/1 (slot[1]=0), minutes in slots 2/3
  assign field_hide_c = adj_en & ~blink_on_q & (slot_q[1] != adj_sel);
`else
  logic unused_adj;
  assign unused_adj   = adj_en ^ adj_sel ^ (BLINK_DIV == 0);
  assign field_hide_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      slot_q  <= SLOT_SEC_ONES;
      conv_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
      hide_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      slot_q  <= slot_n;
      conv_q  <= conv_n;
      seg_q   <= seg_n;
      an_q    <= an_n;
      dp_q    <= dp_n;
      hide_q  <= hide_n;
    end
  end

  // Next-state plus registered-output preparation; hide is latched once per slot
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    slot_n  = slot_q;
    conv_n  = conv_q;
    seg_n   = seg_q;
    hide_n  = hide_q;
    an_n    = AN_OFF;
    dp_n    = 1'b1;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(0)) begin
          conv_n = slot_q[1] ? snap_q.min : snap_q.sec;
        end
        if (cnt_q == CNT_W'(1)) begin
          seg_n   = seg_dec_c;
          hide_n  = field_hide_c;
          state_n = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
          cnt_n   = '0;
          slot_n  = slot_q + SLOT_W'(1);
          state_n = ST_BLANK;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_BLANK;
      end
    endcase

    if (state_n == ST_DRIVE) begin
      an_n = hide_n ? AN_OFF : AN_SLOT[slot_n];
      dp_n = (slot_n != SLOT_MIN_ONES);
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
